// File: rtl/eight_to_thirty_two.sv
// eight_to_thirty_two: byte-to-word deserializer on the div_8_clk domain.
// Packs four bytes (first byte = MSB) into a 32-bit word, pulses data_valid
// on completion, pulses frame_err when rx_start aborts a partial frame, and
// counts completed words (8-bit, wrapping).
// Optional build macro: E2T_HOLD_EN -- when defined, data_out holds the last
// completed word; otherwise data_out is non-zero only in the data_valid cycle.
module eight_to_thirty_two (
    input  logic        div_8_clk,
    input  logic        rst_n,
    input  logic        rx_start,
    input  logic [7:0]  data_in,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        frame_err,
    output logic [7:0]  frame_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] R_1  = 2'd1;
    localparam logic [1:0] R_2  = 2'd2;
    localparam logic [1:0] R_3  = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [23:0] acc;
    logic        load_b0;
    logic        restart;
    logic        complete;

    // Next-state decode; rx_start in any collecting state restarts the frame
    always_comb begin
        state_next = state;
        load_b0    = 1'b0;
        restart    = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_start) begin
                    load_b0    = 1'b1;
                    state_next = R_1;
                end
            end
            R_1, R_2, R_3: begin
                if (rx_start) begin
                    restart    = 1'b1;
                    load_b0    = 1'b1;
                    state_next = R_1;
                end else if (state == R_1) begin
                    state_next = R_2;
                end else if (state == R_2) begin
                    state_next = R_3;
                end else begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and partial-word accumulator
    always_ff @(posedge div_8_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
        end else begin
            state <= state_next;
            if (load_b0) begin
                acc[23:16] <= data_in;
            end else if (state == R_1) begin
                acc[15:8] <= data_in;
            end else if (state == R_2) begin
                acc[7:0] <= data_in;
            end
        end
    end

    // Registered outputs: word, one-cycle pulses and completed-word counter
    always_ff @(posedge div_8_clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            data_valid <= complete;
            frame_err  <= restart;
            if (complete) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
`ifdef E2T_HOLD_EN
            if (complete) begin
                data_out <= {acc, data_in};
            end
`else
            data_out <= complete ? {acc, data_in} : '0;
`endif
        end
    end

endmodule

// File: tb/tb_eight_to_thirty_two.sv
// Directed self-checking bench for eight_to_thirty_two.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_eight_to_thirty_two;

    logic        div_8_clk;
    logic        rst_n;
    logic        rx_start;
    logic [7:0]  data_in;
    logic [31:0] data_out;
    logic        data_valid;
    logic        frame_err;
    logic [7:0]  frame_cnt;

    int unsigned total;
    int unsigned bad;
    logic [7:0]  exp_cnt;
    logic [31:0] word;

    eight_to_thirty_two dut (
        .div_8_clk  (div_8_clk),
        .rst_n      (rst_n),
        .rx_start   (rx_start),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt)
    );

    initial div_8_clk = 1'b0;
    always #5 div_8_clk = ~div_8_clk;

`ifdef E2T_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, advance one rising edge, settle 1 ns
    task automatic step(input logic rs, input logic [7:0] d);
        rx_start = rs;
        data_in  = d;
        @(posedge div_8_clk);
        #1;
    endtask

    task automatic check_idle_out(input string tag, input logic [31:0] last_word);
        check({tag, "_valid"}, 32'(data_valid), 32'd0);
        check({tag, "_dout"}, data_out, HOLD ? last_word : 32'd0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        rx_start = 1'b0;
        data_in  = 8'h00;
        exp_cnt  = 8'd0;

        // Reset state
        #3;
        check("rst_dout", data_out, 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_cnt", 32'(frame_cnt), 32'd0);
        @(negedge div_8_clk);
        rst_n = 1'b1;

        // IDLE ignores data_in without rx_start
        step(1'b0, 8'hFF);
        check("idle_valid", 32'(data_valid), 32'd0);
        check("idle_cnt", 32'(frame_cnt), 32'd0);

        // Single frame DEADBEEF
        step(1'b1, 8'hDE);
        check("f1_b0_valid", 32'(data_valid), 32'd0);
        step(1'b0, 8'hAD);
        step(1'b0, 8'hBE);
        check("f1_b2_valid", 32'(data_valid), 32'd0);
        step(1'b0, 8'hEF);
        exp_cnt = 8'd1;
        check("f1_valid", 32'(data_valid), 32'd1);
        check("f1_dout", data_out, 32'hDEADBEEF);
        check("f1_cnt", 32'(frame_cnt), 32'(exp_cnt));
        check("f1_err", 32'(frame_err), 32'd0);
        step(1'b0, 8'h00);
        check_idle_out("f1_after", 32'hDEADBEEF);

        // Back-to-back frames, second rx_start right after completion edge
        step(1'b1, 8'h01);
        step(1'b0, 8'h02);
        step(1'b0, 8'h03);
        step(1'b0, 8'h04);
        exp_cnt = 8'd2;
        check("b2b1_valid", 32'(data_valid), 32'd1);
        check("b2b1_dout", data_out, 32'h01020304);
        check("b2b1_cnt", 32'(frame_cnt), 32'(exp_cnt));
        step(1'b1, 8'hA5);
        check_idle_out("b2b_gap", 32'h01020304);
        check("b2b_gap_err", 32'(frame_err), 32'd0);
        step(1'b0, 8'hA5);
        step(1'b0, 8'h5A);
        step(1'b0, 8'h5A);
        exp_cnt = 8'd3;
        check("b2b2_valid", 32'(data_valid), 32'd1);
        check("b2b2_dout", data_out, 32'hA5A55A5A);
        check("b2b2_cnt", 32'(frame_cnt), 32'(exp_cnt));

        // Restart during R_2
        step(1'b1, 8'h11);
        step(1'b0, 8'h22);
        step(1'b1, 8'h33);
        check("rs_err", 32'(frame_err), 32'd1);
        check("rs_valid", 32'(data_valid), 32'd0);
        check("rs_cnt", 32'(frame_cnt), 32'(exp_cnt));
        check("rs_dout", data_out, HOLD ? 32'hA5A55A5A : 32'd0);
        step(1'b0, 8'h44);
        check("rs_err_pulse", 32'(frame_err), 32'd0);
        step(1'b0, 8'h55);
        step(1'b0, 8'h66);
        exp_cnt = 8'd4;
        check("rs_valid2", 32'(data_valid), 32'd1);
        check("rs_dout2", data_out, 32'h33445566);
        check("rs_cnt2", 32'(frame_cnt), 32'(exp_cnt));
        check("rs_err2", 32'(frame_err), 32'd0);

        // Restart in R_3: the would-be last byte becomes the new b0
        step(1'b1, 8'h10);
        step(1'b0, 8'h20);
        step(1'b0, 8'h30);
        step(1'b1, 8'h40);
        check("r3_err", 32'(frame_err), 32'd1);
        check("r3_valid", 32'(data_valid), 32'd0);
        check("r3_cnt", 32'(frame_cnt), 32'(exp_cnt));
        step(1'b0, 8'h50);
        step(1'b0, 8'h60);
        step(1'b0, 8'h70);
        exp_cnt = 8'd5;
        check("r3_dout", data_out, 32'h40506070);
        check("r3_cnt2", 32'(frame_cnt), 32'(exp_cnt));

        // Reset mid-frame, asserted between edges
        step(1'b1, 8'h99);
        step(1'b0, 8'h88);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_dout", data_out, 32'd0);
        check("mrst_cnt", 32'(frame_cnt), 32'd0);
        check("mrst_err", 32'(frame_err), 32'd0);
        step(1'b0, 8'h77);
        check("mrst_valid", 32'(data_valid), 32'd0);
        @(negedge div_8_clk);
        rst_n = 1'b1;
        step(1'b1, 8'hCA);
        step(1'b0, 8'hFE);
        step(1'b0, 8'hF0);
        check("mrst_novalid", 32'(data_valid), 32'd0);
        step(1'b0, 8'h0D);
        check("cafe_valid", 32'(data_valid), 32'd1);
        check("cafe_dout", data_out, 32'hCAFEF00D);
        check("cafe_cnt", 32'(frame_cnt), 32'd1);
        check("cafe_err", 32'(frame_err), 32'd0);

        // Hold option: 12345678 then three idle cycles
        step(1'b1, 8'h12);
        step(1'b0, 8'h34);
        step(1'b0, 8'h56);
        step(1'b0, 8'h78);
        check("hold_dout0", data_out, 32'h12345678);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'hEE);
            check_idle_out("hold_idle", 32'h12345678);
        end
        check("hold_cnt", 32'(frame_cnt), 32'd2);

        // Counter wrap: 254 more frames reach 0
        for (int n = 0; n < 254; n++) begin
            word = 32'h01010101 * 32'(n) ^ 32'h5A3C0F96;
            step(1'b1, word[31:24]);
            step(1'b0, word[23:16]);
            step(1'b0, word[15:8]);
            step(1'b0, word[7:0]);
            if (n == 253) begin
                check("wrap_valid", 32'(data_valid), 32'd1);
                check("wrap_dout", data_out, word);
            end else if (n == 252) begin
                check("wrap_cnt255", 32'(frame_cnt), 32'd255);
            end
        end
        check("wrap_cnt0", 32'(frame_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
